// File: rtl/ser_frame_transmitter.sv
// Serial framed-link transmitter: start flag, MSB-first payload from a one-byte holding
// register, and an abort pattern on request, underrun or payload overrun.
module ser_frame_transmitter #(
    parameter logic [7:0]  FLAG_SEQ  = 8'b01111110,
    parameter logic [7:0]  ABORT_SEQ = 8'b10000001,
    parameter int unsigned MAX_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inData,
    input  logic       inLast,
    input  logic       inValid,
    output logic       inReady,
    input  logic       abortReq,
    output logic       txOut,
    output logic       txValid,
    output logic       txBusy,
    output logic       txDone,
    output logic       txUnderrun
);

    localparam int unsigned CntW = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {StIdle, StFlag, StData, StAbort} state_e;

    state_e          state_q;
    logic [7:0]      shift_q;
    logic [7:0]      hold_q;
    logic            hold_last_q;
    logic            hold_full_q;
    logic            cur_last_q;
    logic [2:0]      bit_cnt_q;
    logic [CntW-1:0] byte_cnt_q;

    logic accept;
    logic boundary;
    logic more_ok;
    logic go_abort;

    assign inReady  = !hold_full_q && (state_q != StAbort);
    assign accept   = inValid && inReady;
    assign more_ok  = hold_full_q && (byte_cnt_q < CntW'(MAX_BYTES));
    assign boundary = (state_q == StData) && (bit_cnt_q == 3'd7) && !abortReq;

    // Pulses coincide with the final bit on the line, and an abort on that edge suppresses them.
    assign txDone     = boundary && cur_last_q;
    assign txUnderrun = boundary && !cur_last_q && !hold_full_q;

    assign go_abort = ((state_q == StFlag) && abortReq) ||
                      ((state_q == StData) &&
                       (abortReq || ((bit_cnt_q == 3'd7) && !cur_last_q && !more_ok)));

    // The shifter MSB is the line; it is cleared whenever the FSM returns to idle.
    assign txOut   = shift_q[7];
    assign txBusy  = (state_q != StIdle);
    assign txValid = txBusy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            cur_last_q  <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= '0;
        end else begin
            if (accept) begin
                hold_q      <= inData;
                hold_last_q <= inLast;
                hold_full_q <= 1'b1;
            end

            if (go_abort) begin
                // Written after the accept so a same-edge handshake is discarded.
                state_q     <= StAbort;
                shift_q     <= ABORT_SEQ;
                hold_full_q <= 1'b0;
                bit_cnt_q   <= 3'd0;
                byte_cnt_q  <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (hold_full_q) begin
                            state_q   <= StFlag;
                            shift_q   <= FLAG_SEQ;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    StFlag: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q     <= StData;
                            shift_q     <= hold_q;
                            cur_last_q  <= hold_last_q;
                            hold_full_q <= 1'b0;
                            byte_cnt_q  <= CntW'(1);
                        end else begin
                            shift_q <= {shift_q[6:0], 1'b0};
                        end
                    end
                    StData: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (cur_last_q) begin
                                state_q    <= StIdle;
                                shift_q    <= 8'd0;
                                byte_cnt_q <= '0;
                            end else begin
                                shift_q     <= hold_q;
                                cur_last_q  <= hold_last_q;
                                hold_full_q <= 1'b0;
                                byte_cnt_q  <= byte_cnt_q + CntW'(1);
                            end
                        end else begin
                            shift_q <= {shift_q[6:0], 1'b0};
                        end
                    end
                    StAbort: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StIdle;
                            shift_q <= 8'd0;
                        end else begin
                            shift_q <= {shift_q[6:0], 1'b0};
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        shift_q <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_frame_transmitter.sv
// Scoreboard bench: dut0 uses MAX_BYTES=16, dut1 uses MAX_BYTES=2 for the overrun and reset cases.
module tb_ser_frame_transmitter;

    typedef struct packed {
        logic o;
        logic d;
        logic u;
    } exp_t;

    localparam logic [7:0] FLAG = 8'h7E;
    localparam logic [7:0] ABRT = 8'h81;

    logic       clk = 1'b0;
    logic       rst       [2];
    logic [7:0] in_data   [2];
    logic       in_last   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic       abort_req [2];
    logic       tx_out    [2];
    logic       tx_valid  [2];
    logic       tx_busy   [2];
    logic       tx_done   [2];
    logic       tx_under  [2];

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ser_frame_transmitter dut0 (
        .clk(clk), .rst(rst[0]), .inData(in_data[0]), .inLast(in_last[0]),
        .inValid(in_valid[0]), .inReady(in_ready[0]), .abortReq(abort_req[0]),
        .txOut(tx_out[0]), .txValid(tx_valid[0]), .txBusy(tx_busy[0]),
        .txDone(tx_done[0]), .txUnderrun(tx_under[0])
    );

    ser_frame_transmitter #(.MAX_BYTES(2)) dut1 (
        .clk(clk), .rst(rst[1]), .inData(in_data[1]), .inLast(in_last[1]),
        .inValid(in_valid[1]), .inReady(in_ready[1]), .abortReq(abort_req[1]),
        .txOut(tx_out[1]), .txValid(tx_valid[1]), .txBusy(tx_busy[1]),
        .txDone(tx_done[1]), .txUnderrun(tx_under[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input int w, input logic [7:0] b, input int n,
                             input bit done_end, input bit und_end);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.o = b[7-i];
            e.d = (i == n - 1) && done_end;
            e.u = (i == n - 1) && und_end;
            if (w == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic mon(input int w, input logic o, input logic v, input logic d, input logic u);
        exp_t e;
        bit   have;
        if (!v) begin
            chk($sformatf("dut%0d idle_txout", w), o, 0);
            chk($sformatf("dut%0d idle_txdone", w), d, 0);
            chk($sformatf("dut%0d idle_txunderrun", w), u, 0);
        end else begin
            have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
            chk($sformatf("dut%0d sb_has_entry", w), have, 1);
            if (have) begin
                e = (w == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d txout", w), o, e.o);
                chk($sformatf("dut%0d txdone", w), d, e.d);
                chk($sformatf("dut%0d txunderrun", w), u, e.u);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, tx_out[0], tx_valid[0], tx_done[0], tx_under[0]);
        mon(1, tx_out[1], tx_valid[1], tx_done[1], tx_under[1]);
    end

    // Returns at the first negedge after the handshake edge.
    task automatic put(input int w, input logic [7:0] d, input logic l, output logic busy_at);
        int n = 0;
        @(negedge clk);
        in_data[w]  = d;
        in_last[w]  = l;
        in_valid[w] = 1'b1;
        while (!in_ready[w] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("put_ready_timeout", in_ready[w], 1);
        busy_at = tx_busy[w];
        @(posedge clk);
        #1;
        in_valid[w] = 1'b0;
        @(negedge clk);
        chk("ready_low_after_accept", in_ready[w], 0);
    endtask

    task automatic wait_idle(input int w);
        int n = 0;
        while (!tx_busy[w] && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx_busy[w] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", tx_busy[w], 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic b;
        for (int w = 0; w < 2; w++) begin
            rst[w] = 1'b1;
            in_data[w] = 8'd0;
            in_last[w] = 1'b0;
            in_valid[w] = 1'b0;
            abort_req[w] = 1'b0;
        end
        #3;
        chk("reset_ready", in_ready[0], 1);
        chk("reset_txout", tx_out[0], 0);
        chk("reset_busy", tx_busy[0], 0);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Test 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", in_ready[0], 1);
        end

        // Test 2: single-byte frame
        push_bits(0, FLAG, 8, 0, 0);
        push_bits(0, 8'hA5, 8, 1, 0);
        put(0, 8'hA5, 1'b1, b);
        wait_idle(0);

        // Test 3: three back-to-back bytes, 32 contiguous valid bits
        push_bits(0, FLAG, 8, 0, 0);
        push_bits(0, 8'h01, 8, 0, 0);
        push_bits(0, 8'hFF, 8, 0, 0);
        push_bits(0, 8'h3C, 8, 1, 0);
        fork
            begin
                put(0, 8'h01, 1'b0, b);
                put(0, 8'hFF, 1'b0, b);
                put(0, 8'h3C, 1'b1, b);
            end
            begin
                int n = 0;
                int run = 0;
                @(negedge clk);
                while (!tx_valid[0] && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                while (tx_valid[0] && run < 100) begin
                    run++;
                    @(negedge clk);
                end
                chk("run_length", run, 32);
            end
        join
        wait_idle(0);

        // Test 4: late second byte -> underrun then abort, byte then sent as new frame
        push_bits(0, FLAG, 8, 0, 0);
        push_bits(0, 8'h96, 8, 0, 1);
        push_bits(0, ABRT, 8, 0, 0);
        push_bits(0, FLAG, 8, 0, 0);
        push_bits(0, 8'h42, 8, 1, 0);
        put(0, 8'h96, 1'b0, b);
        repeat (20) @(negedge clk);
        put(0, 8'h42, 1'b1, b);
        chk("late_byte_busy_at_accept", b, 0);
        wait_idle(0);

        // Test 5: abort during bit 3 of byte 2; a byte offered during abort waits for idle
        push_bits(0, FLAG, 8, 0, 0);
        push_bits(0, 8'h5A, 8, 0, 0);
        push_bits(0, 8'hC3, 4, 0, 0);
        push_bits(0, ABRT, 8, 0, 0);
        push_bits(0, FLAG, 8, 0, 0);
        push_bits(0, 8'h99, 8, 1, 0);
        fork
            begin
                put(0, 8'h5A, 1'b0, b);
                put(0, 8'hC3, 1'b1, b);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!tx_valid[0] && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                repeat (19) @(negedge clk);
                abort_req[0] = 1'b1;
                @(negedge clk);
                abort_req[0] = 1'b0;
                chk("ready_in_abort", in_ready[0], 0);
                chk("busy_in_abort", tx_busy[0], 1);
            end
        join
        put(0, 8'h99, 1'b1, b);
        chk("abort_byte_busy_at_accept", b, 0);
        wait_idle(0);

        // Test 6: MAX_BYTES=2 overrun, then async reset mid-data, then clean frame
        push_bits(1, FLAG, 8, 0, 0);
        push_bits(1, 8'h11, 8, 0, 0);
        push_bits(1, 8'h22, 8, 0, 0);
        push_bits(1, ABRT, 8, 0, 0);
        put(1, 8'h11, 1'b0, b);
        put(1, 8'h22, 1'b0, b);
        put(1, 8'h33, 1'b0, b);
        wait_idle(1);

        push_bits(1, FLAG, 8, 0, 0);
        push_bits(1, 8'hFF, 4, 0, 0);
        put(1, 8'hFF, 1'b0, b);
        repeat (12) @(negedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        chk("async_rst_txout", tx_out[1], 0);
        chk("async_rst_busy", tx_busy[1], 0);
        chk("async_rst_ready", in_ready[1], 1);
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        push_bits(1, FLAG, 8, 0, 0);
        push_bits(1, 8'h3C, 8, 1, 0);
        put(1, 8'h3C, 1'b1, b);
        wait_idle(1);

        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
